dec7seg_scan: RTL and testbench

Multiplexed multi-digit 7-segment display driver, the parametrised successor to the single-digit DEC7SEG decoder. It latches an `NDIG`-digit hex value, with one decimal point per digit, and scans the digits time-multiplexed onto one shared segment bus with a one-hot digit enable. New values are double-buffered and take effect only at a frame boundary, so a frame never mixes old and new digits. Optional leading-zero suppression is provided. It sits between the register/control logic and the board's display pins.

---
 rtl/dec7seg_scan.sv | 156 +++++++++++++++
 tb/tb_dec7seg_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dec7seg_scan.sv
// rtl/dec7seg_scan.sv - multiplexed NDIG-digit hex 7-segment scanner with frame-aligned double buffering
// Optional: define DEC7SEG_GHOST_GUARD_EN to blank DIG during the first two cycles of each digit slot.
module dec7seg_scan #(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD,
    input  logic [4*NDIG-1:0] DATA,
    input  logic [NDIG-1:0]   DP,
    input  logic              LZS,
    output logic [7:0]        LED,
    output logic [NDIG-1:0]   DIG,
    output logic              PEND,
    output logic              FRAME
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef DEC7SEG_GHOST_GUARD_EN
    generate
        if (DIV < 3) begin : g_div_check
            $error("dec7seg_scan: ghost guard needs DIV >= 3");
        end
    endgenerate
`endif

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] act_data_q, act_data_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    logic [4*NDIG-1:0] sh_data_q, sh_data_d;
    logic [NDIG-1:0]   sh_dp_q, sh_dp_d;
    logic              pend_q, pend_d;
    logic              frame_q, frame_d;
    logic [7:0]        led_q, led_d;
    logic [NDIG-1:0]   dig_q, dig_d;

    logic              slot_end;
    logic              boundary;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              upper_zero;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 7'b1111110;
            4'h1:    seg7 = 7'b0110000;
            4'h2:    seg7 = 7'b1101101;
            4'h3:    seg7 = 7'b1111001;
            4'h4:    seg7 = 7'b0110011;
            4'h5:    seg7 = 7'b1011011;
            4'h6:    seg7 = 7'b1011111;
            4'h7:    seg7 = 7'b1110000;
            4'h8:    seg7 = 7'b1111111;
            4'h9:    seg7 = 7'b1111011;
            4'hA:    seg7 = 7'b1110111;
            4'hB:    seg7 = 7'b0011111;
            4'hC:    seg7 = 7'b0001101;
            4'hD:    seg7 = 7'b0111101;
            4'hE:    seg7 = 7'b1001111;
            default: seg7 = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        slot_end   = (cnt_q == CW'(DIV - 1));
        boundary   = slot_end && (idx_q == IW'(NDIG - 1));

        cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end

        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        pend_d     = pend_q;
        if (LOAD) begin
            sh_data_d = DATA;
            sh_dp_d   = DP;
        end
        // A load landing exactly on the boundary bypasses the shadow so it is not held a whole frame.
        if (LOAD && boundary) begin
            act_data_d = DATA;
            act_dp_d   = DP;
            pend_d     = 1'b0;
        end else if (LOAD) begin
            pend_d     = 1'b1;
        end else if (boundary && pend_q) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            pend_d     = 1'b0;
        end

        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        upper_zero = 1'b1;
        dig_d      = '0;
        // Walk from the most significant digit so upper_zero covers this digit and all above it.
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_data_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib   = act_data_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = LZS && (i != 0) && upper_zero;
                dig_d[i]  = 1'b1;
            end
        end
`ifdef DEC7SEG_GHOST_GUARD_EN
        if (cnt_q < CW'(2)) begin
            dig_d = '0;
        end
`endif
        led_d   = {(cur_blank ? 7'b0000000 : seg7(cur_nib)), cur_dp};
        frame_d = boundary;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            pend_q     <= 1'b0;
            frame_q    <= 1'b0;
            led_q      <= '0;
            dig_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            pend_q     <= pend_d;
            frame_q    <= frame_d;
            led_q      <= led_d;
            dig_q      <= dig_d;
        end
    end

    assign LED   = led_q;
    assign DIG   = dig_q;
    assign PEND  = pend_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_dec7seg_scan.sv
// tb/tb_dec7seg_scan.sv - scoreboard bench for dec7seg_scan with NDIG=4, DIV=4
module tb_dec7seg_scan;

    localparam int NDIG = 4;
    localparam int DIV  = 4;

    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic        LOAD = 1'b0;
    logic        LZS  = 1'b0;
    logic [15:0] DATA = '0;
    logic [3:0]  DP   = '0;
    logic [7:0]  LED;
    logic [3:0]  DIG;
    logic        PEND;
    logic        FRAME;

    dec7seg_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .DP(DP), .LZS(LZS),
        .LED(LED), .DIG(DIG), .PEND(PEND), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pend;
        logic       frame;
        logic [3:0] dig;
        logic [7:0] led;
    } exp_t;

    exp_t sb_q[$];
    int   errs   = 0;
    int   checks = 0;
    int   k      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111};
        return tbl[n];
    endfunction

    // Expected outputs after edge kk counted from reset release.
    function automatic exp_t exp_at(input int kk, input logic [15:0] d, input logic [3:0] p,
                                    input logic lz, input logic pe);
        exp_t e;
        int   dg;
        logic blank;
        dg      = ((kk - 1) / DIV) % NDIG;
        blank   = lz && (dg > 0) && ((d >> (4 * dg)) == 16'h0);
        e.dig   = 4'(1) << dg;
        e.led   = {(blank ? 7'b0000000 : seg_of(d[4*dg +: 4])), p[dg]};
        e.frame = ((kk % (NDIG * DIV)) == 0);
        e.pend  = pe;
        return e;
    endfunction

    task automatic push_range(input int k0, input int k1, input logic [15:0] d,
                              input logic [3:0] p, input logic lz, input logic pe);
        for (int kk = k0; kk <= k1; kk++) sb_q.push_back(exp_at(kk, d, p, lz, pe));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        @(negedge CLK);
        k++;
        LOAD = 1'b0;
        if (sb_q.size() == 0) begin
            check_eq($sformatf("k%0d sb_empty", k), 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("k%0d dig", k),   {28'd0, DIG},   {28'd0, e.dig});
            check_eq($sformatf("k%0d led", k),   {24'd0, LED},   {24'd0, e.led});
            check_eq($sformatf("k%0d pend", k),  {31'd0, PEND},  {31'd0, e.pend});
            check_eq($sformatf("k%0d frame", k), {31'd0, FRAME}, {31'd0, e.frame});
        end
    endtask

    task automatic run_to(input int kend);
        while (k < kend) tick();
    endtask

    task automatic load_at(input int kk, input logic [15:0] d, input logic [3:0] p);
        run_to(kk - 1);
        DATA = d;
        DP   = p;
        LOAD = 1'b1;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " led"},   {24'd0, LED},   32'd0);
        check_eq({tag, " dig"},   {28'd0, DIG},   32'd0);
        check_eq({tag, " pend"},  {31'd0, PEND},  32'd0);
        check_eq({tag, " frame"}, {31'd0, FRAME}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST  = 1'b1;
        LOAD = 1'b0;
        @(posedge CLK);
        #1;
        check_zero("rst");
        @(negedge CLK);
        RST = 1'b0;
        k   = 0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scan order and first-edge values after reset.
        do_reset();
        push_range(1, 15, 16'h0, 4'h0, 1'b0, 1'b1);
        push_range(16, 16, 16'h0, 4'h0, 1'b0, 1'b0);
        push_range(17, 32, 16'h12AF, 4'b0100, 1'b0, 1'b0);
        load_at(1, 16'h12AF, 4'b0100);
        run_to(32);

        // Buffered load mid-frame.
        do_reset();
        push_range(1, 15, 16'h0, 4'h0, 1'b0, 1'b1);
        push_range(16, 16, 16'h0, 4'h0, 1'b0, 1'b0);
        push_range(17, 21, 16'h1111, 4'h0, 1'b0, 1'b0);
        push_range(22, 31, 16'h1111, 4'h0, 1'b0, 1'b1);
        push_range(32, 32, 16'h1111, 4'h0, 1'b0, 1'b0);
        push_range(33, 48, 16'h2222, 4'h0, 1'b0, 1'b0);
        load_at(1, 16'h1111, 4'h0);
        load_at(22, 16'h2222, 4'h0);
        run_to(48);

        // Last load wins, then a load on the boundary edge itself.
        do_reset();
        push_range(1, 2, 16'h0, 4'h0, 1'b0, 1'b0);
        push_range(3, 15, 16'h0, 4'h0, 1'b0, 1'b1);
        push_range(16, 16, 16'h0, 4'h0, 1'b0, 1'b0);
        push_range(17, 32, 16'h4444, 4'h0, 1'b0, 1'b0);
        push_range(33, 40, 16'h5555, 4'hF, 1'b0, 1'b0);
        load_at(3, 16'h3333, 4'h0);
        load_at(10, 16'h4444, 4'h0);
        load_at(32, 16'h5555, 4'hF);
        run_to(40);

        // Leading-zero suppression, including dp on blanked digits.
        LZS = 1'b1;
        do_reset();
        push_range(1, 15, 16'h0, 4'h0, 1'b1, 1'b1);
        push_range(16, 16, 16'h0, 4'h0, 1'b1, 1'b0);
        push_range(17, 31, 16'h0050, 4'h0, 1'b1, 1'b1);
        push_range(32, 32, 16'h0050, 4'h0, 1'b1, 1'b0);
        push_range(33, 48, 16'h0000, 4'b1001, 1'b1, 1'b0);
        load_at(1, 16'h0050, 4'h0);
        load_at(17, 16'h0000, 4'b1001);
        run_to(48);
        LZS = 1'b0;

        // Asynchronous reset mid-frame with a load pending.
        do_reset();
        push_range(1, 8, 16'h0, 4'h0, 1'b0, 1'b0);
        push_range(9, 10, 16'h0, 4'h0, 1'b0, 1'b1);
        load_at(9, 16'hAAAA, 4'hF);
        run_to(10);
        #2;
        RST = 1'b1;
        #1;
        check_zero("async_rst");
        do_reset();
        push_range(1, 20, 16'h0, 4'h0, 1'b0, 1'b0);
        run_to(20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
